// File: rtl/axi_stream_insert_header_if.sv
// Bus bundle for the header inserter: payload input channel, header side
// channel and the re-packed output channel.
//   valid_in/data_in/keep_in/last_in/ready_in          payload input
//   valid_insert/header_insert/keep_insert/
//   byte_insert_cnt/ready_insert                        header side channel
//   valid_out/data_out/keep_out/last_out/ready_out      packed output
// slave is the inserter's view; master is the source/sink view.
interface axi_stream_insert_header_if #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      header_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD:0]    byte_insert_cnt;
    logic                    ready_insert;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        output ready_in,
        output valid_out, data_out, keep_out, last_out,
        input  ready_out,
        input  valid_insert, header_insert, keep_insert, byte_insert_cnt,
        output ready_insert
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        input  ready_in,
        input  valid_out, data_out, keep_out, last_out,
        output ready_out,
        output valid_insert, header_insert, keep_insert, byte_insert_cnt,
        input  ready_insert
    );
endinterface

// File: rtl/axi_stream_insert_header.sv
// Streaming header inserter. Captures one header per packet from the side
// channel, prepends its byte_insert_cnt bytes to the payload and re-packs the
// combined stream into dense MSB-first output beats.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave view of axi_stream_insert_header_if (payload in, header in,
//          packed out). data/keep/last/valid out are registered; ready_in and
//          ready_insert are decoded from state and the output register.
module axi_stream_insert_header #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi_stream_insert_header_if.slave bus
);
    localparam int unsigned W      = DATA_BYTE_WD;
    localparam int unsigned CNT_WD = BYTE_CNT_WD + 1;
    localparam int unsigned SUM_WD = BYTE_CNT_WD + 2;
    localparam int unsigned SH_WD  = $clog2(DATA_WD) + 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_WD-1:0] r_q, r_d;
    logic [CNT_WD-1:0]  s_q, s_d;
    logic               valid_q, valid_d;
    logic [DATA_WD-1:0] data_q, data_d;
    logic [W-1:0]       keep_q, keep_d;
    logic               last_q, last_d;

    logic               out_ld;
    logic               in_fire;
    logic               hdr_fire;
    logic               ready_in_c;
    logic               ready_insert_c;
    logic [DATA_WD-1:0] din_m;
    logic [DATA_WD-1:0] hdr_al;
    logic [SUM_WD-1:0]  n_in;
    logic [SUM_WD-1:0]  tot;
    logic [SH_WD-1:0]   sh_s;
    logic [SH_WD-1:0]   sh_rem;
    logic [SH_WD-1:0]   sh_hdr;
    logic               unused_keep_insert;

    // Expand byte enables into a bit mask (keep bit i covers data bits 8i+7..8i).
    function automatic logic [DATA_WD-1:0] byte_mask(input logic [W-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < W; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    // MSB-aligned keep with k ones.
    function automatic logic [W-1:0] top_ones(input logic [SUM_WD-1:0] k);
        logic [W-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < W; i++) begin
            t[W-1-i] = (SUM_WD'(i) < k);
        end
        return t;
    endfunction

    function automatic logic [SUM_WD-1:0] popcount(input logic [W-1:0] k);
        logic [SUM_WD-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < W; i++) begin
            n = n + SUM_WD'(k[i]);
        end
        return n;
    endfunction

    // Handshake decode; the output register may load when empty or draining.
    assign out_ld         = !valid_q || bus.ready_out;
    assign ready_in_c     = (state_q == DATA) && out_ld;
    assign ready_insert_c = (state_q == IDLE) && rst_n;
    assign in_fire        = bus.valid_in && ready_in_c;
    assign hdr_fire       = bus.valid_insert && ready_insert_c;

    // Byte alignment: residual occupies the top S bytes, payload slides in below.
    assign din_m  = bus.data_in & byte_mask(bus.keep_in);
    assign n_in   = popcount(bus.keep_in);
    assign tot    = SUM_WD'(s_q) + n_in;
    assign sh_s   = SH_WD'(s_q) << 3;
    assign sh_rem = (SH_WD'(W) - SH_WD'(s_q)) << 3;
    assign sh_hdr = (SH_WD'(W) - SH_WD'(bus.byte_insert_cnt)) << 3;
    assign hdr_al = bus.header_insert << sh_hdr;

    // Header byte enables are informational; the count is authoritative.
    assign unused_keep_insert = ^bus.keep_insert;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    // Next-state and output-register load logic.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        s_d     = s_q;
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (out_ld) begin
                    valid_d = 1'b0;
                end
                if (hdr_fire) begin
                    r_d     = hdr_al;
                    s_d     = CNT_WD'(bus.byte_insert_cnt);
                    state_d = DATA;
                end
            end

            DATA: begin
                if (out_ld) begin
                    valid_d = 1'b0;
                end
                if (in_fire) begin
                    valid_d = 1'b1;
                    data_d  = r_q | (din_m >> sh_s);
                    if (!bus.last_in) begin
                        keep_d = '1;
                        last_d = 1'b0;
                        r_d    = din_m << sh_rem;
                    end else if (tot <= SUM_WD'(W)) begin
                        keep_d  = top_ones(tot);
                        last_d  = 1'b1;
                        r_d     = '0;
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        // Remainder spills into one extra beat.
                        keep_d  = '1;
                        last_d  = 1'b0;
                        r_d     = din_m << sh_rem;
                        s_d     = CNT_WD'(tot - SUM_WD'(W));
                        state_d = FLUSH;
                    end
                end
            end

            FLUSH: begin
                if (out_ld) begin
                    valid_d = 1'b1;
                    data_d  = r_q;
                    keep_d  = top_ones(SUM_WD'(s_q));
                    last_d  = 1'b1;
                    r_d     = '0;
                    s_d     = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready_in     = ready_in_c;
    assign bus.ready_insert = ready_insert_c;
    assign bus.valid_out    = valid_q;
    assign bus.data_out     = data_q;
    assign bus.keep_out     = keep_q;
    assign bus.last_out     = last_q;
endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Randomized self-checking bench for axi_stream_insert_header. The reference
// model flattens header bytes plus payload bytes into one byte queue and cuts
// it into W-byte output beats; a monitor compares every valid output beat
// against the head of that expected-beat queue.
module tb_axi_stream_insert_header;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned CW    = $clog2(BW);
    localparam int unsigned CNT_W = CW + 1;

    logic clk;
    logic rst_n;

    axi_stream_insert_header_if #(.DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW)) bus ();

    axi_stream_insert_header #(.DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_rdy = 1'b0;
    bit gaps     = 1'b0;

    logic [DW-1:0] pkt_data[$];
    logic [BW-1:0] pkt_keep[$];
    logic [DW+BW:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes in wire order, cut into dense MSB-first beats.
    task automatic build_expected(input int h, input logic [DW-1:0] hdr);
        logic [7:0]    bq[$];
        logic [DW-1:0] d;
        logic [BW-1:0] k;
        int            n;
        for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
        foreach (pkt_data[b]) begin
            n = 0;
            for (int j = 0; j < int'(BW); j++) n += int'(pkt_keep[b][j]);
            d = pkt_data[b];
            for (int j = 0; j < n; j++) bq.push_back(d[DW-1-8*j -: 8]);
        end
        while (bq.size() > 0) begin
            d = '0;
            k = '0;
            for (int j = 0; j < int'(BW); j++) begin
                if (bq.size() > 0) begin
                    d[DW-1-8*j -: 8] = bq.pop_front();
                    k[BW-1-j] = 1'b1;
                end
            end
            exp_q.push_back({bq.size() == 0, k, d});
        end
    endtask

    // Output monitor: every valid beat must equal the model's next beat.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.valid_out) begin
                check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    check("out_beat", 64'({bus.last_out, bus.keep_out, bus.data_out}), 64'(exp_q[0]));
                    if (bus.ready_out) void'(exp_q.pop_front());
                    else check("ready_in_stall", 64'(bus.ready_in), 64'(0));
                end
            end
        end
    end

    // Random downstream backpressure.
    initial begin
        bus.ready_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.ready_out = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic wait_hs(input bit is_hdr);
        int c;
        bit ok;
        c  = 0;
        ok = 1'b0;
        while (!ok && c < 1000) begin
            @(negedge clk);
            ok = is_hdr ? bus.ready_insert : bus.ready_in;
            @(posedge clk);
            #1;
            c++;
        end
        if (is_hdr) check("hdr_handshake", 64'(ok), 64'(1));
        else        check("beat_handshake", 64'(ok), 64'(1));
    endtask

    task automatic send_hdr(input int h, input logic [DW-1:0] hdr);
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.valid_insert    = 1'b1;
        bus.header_insert   = hdr;
        bus.byte_insert_cnt = CNT_W'(h);
        bus.keep_insert     = ~({BW{1'b1}} << h);
        wait_hs(1'b1);
        bus.valid_insert    = 1'b0;
    endtask

    task automatic send_beats(input int nb);
        for (int b = 0; b < nb; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                bus.valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.valid_in = 1'b1;
            bus.data_in  = pkt_data[b];
            bus.keep_in  = pkt_keep[b];
            bus.last_in  = (b == int'(pkt_data.size()) - 1);
            wait_hs(1'b0);
        end
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic run_packet(input int h, input logic [DW-1:0] hdr);
        build_expected(h, hdr);
        send_hdr(h, hdr);
        send_beats(int'(pkt_data.size()));
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rand_rdy         = 1'b0;
        bus.valid_in     = 1'b0;
        bus.valid_insert = 1'b0;
        bus.last_in      = 1'b0;
        bus.ready_out    = 1'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_valid_out", 64'(bus.valid_out), 64'(0));
        check("rst_data_out", 64'(bus.data_out), 64'(0));
        check("rst_keep_out", 64'(bus.keep_out), 64'(0));
        check("rst_last_out", 64'(bus.last_out), 64'(0));
        check("rst_ready_in", 64'(bus.ready_in), 64'(0));
        check("rst_ready_insert", 64'(bus.ready_insert), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_random(output int h, output logic [DW-1:0] hdr);
        int            nb;
        logic [BW-1:0] lk;
        h   = $urandom_range(0, BW);
        hdr = $urandom;
        nb  = $urandom_range(1, 6);
        lk  = ~({BW{1'b1}} >> $urandom_range(1, BW));
        pkt_data.delete();
        pkt_keep.delete();
        for (int b = 0; b < nb; b++) begin
            pkt_data.push_back($urandom);
            pkt_keep.push_back((b == nb - 1) ? lk : {BW{1'b1}});
        end
    endtask

    initial begin
        int            h;
        logic [DW-1:0] hdr;

        rst_n               = 1'b1;
        bus.valid_in        = 1'b0;
        bus.data_in         = '0;
        bus.keep_in         = '0;
        bus.last_in         = 1'b0;
        bus.valid_insert    = 1'b0;
        bus.header_insert   = '0;
        bus.keep_insert     = '0;
        bus.byte_insert_cnt = '0;

        // Normal packet, 3-byte header, last beat fits.
        do_reset();
        bus.ready_out = 1'b1;
        pkt_data = '{32'h0A0B0C0D, 32'h0E0F0001, 32'h02030405, 32'h06070809, 32'h0A0B0B0B};
        pkt_keep = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h8};
        run_packet(3, 32'h000E0D0C);
        drain();

        // Same packet, last beat spills into a flush beat.
        do_reset();
        bus.ready_out = 1'b1;
        pkt_keep = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hC};
        run_packet(3, 32'h000E0D0C);
        drain();

        // Pass-through with an empty header.
        do_reset();
        bus.ready_out = 1'b1;
        pkt_data = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        pkt_keep = '{4'hF, 4'hF, 4'hE};
        run_packet(0, 32'hFFFFFFFF);
        drain();

        // Full-width header.
        do_reset();
        bus.ready_out = 1'b1;
        pkt_data = '{32'hAABBCCDD};
        pkt_keep = '{4'hF};
        run_packet(4, 32'h11223344);
        drain();

        // Payload before header is stalled.
        do_reset();
        bus.ready_out = 1'b1;
        bus.valid_in  = 1'b1;
        bus.data_in   = 32'h55667788;
        bus.keep_in   = 4'hF;
        bus.last_in   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("gate_ready_in", 64'(bus.ready_in), 64'(0));
            check("gate_valid_out", 64'(bus.valid_out), 64'(0));
            @(posedge clk);
            #1;
        end
        bus.valid_in = 1'b0;
        pkt_data = '{32'h55667788, 32'h99AABBCC};
        pkt_keep = '{4'hF, 4'hF};
        run_packet(2, 32'h0000A1A2);
        drain();

        // Reset in the middle of a packet.
        do_reset();
        bus.ready_out = 1'b1;
        pkt_data = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000};
        pkt_keep = '{4'hF, 4'hF, 4'hF, 4'hF};
        build_expected(2, 32'h0000BEEF);
        send_hdr(2, 32'h0000BEEF);
        send_beats(2);
        bus.ready_out = 1'b0;
        #1;
        check("pre_rst_valid_out", 64'(bus.valid_out), 64'(1));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid_out", 64'(bus.valid_out), 64'(0));
        check("mid_rst_keep_out", 64'(bus.keep_out), 64'(0));
        check("mid_rst_ready_in", 64'(bus.ready_in), 64'(0));
        check("mid_rst_ready_insert", 64'(bus.ready_insert), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready_out = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_valid_out", 64'(bus.valid_out), 64'(0));
            check("post_rst_ready_insert", 64'(bus.ready_insert), 64'(1));
            check("post_rst_ready_in", 64'(bus.ready_in), 64'(0));
        end
        @(posedge clk);
        #1;

        // Randomized packets with gaps and backpressure.
        do_reset();
        rand_rdy = 1'b1;
        gaps     = 1'b1;
        for (int p = 0; p < 40; p++) begin
            gen_random(h, hdr);
            run_packet(h, hdr);
        end
        drain();
        rand_rdy = 1'b0;
        gaps     = 1'b0;
        bus.ready_out = 1'b1;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_stream_insert_header.md
# axi_stream_insert_header

Streaming header inserter on an AXI-Stream-style byte path. For each packet it accepts one header word on a side channel, then prepends that header's valid bytes to the payload. The combined stream is re-packed so that output beats are densely filled, MSB byte first. It sits between a packet source and a downstream AXI-Stream sink, with full valid/ready backpressure on all three channels.

## Interface
- DATA_WD, 32, data bus width in bits (multiple of 8, ≥16).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat; also the keep width.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width base for the byte count.
- Clocking/reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  payload beat valid.
- data_in  in  DATA_WD  payload data; byte 0 = data_in[DATA_WD-1 -: 8], first on the wire.
- keep_in  in  DATA_BYTE_WD  byte enables; bit DATA_BYTE_WD-1 marks byte 0.
- last_in  in  1  final payload beat of the packet.
- ready_in  out  1  payload beat accepted when valid_in & ready_in.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  output data; unused bytes are 0.
- keep_out  out  DATA_BYTE_WD  output byte enables, MSB-aligned and contiguous.
- last_out  out  1  final output beat of the packet.
- ready_out  in  1  downstream ready.
- valid_insert  in  1  header valid.
- header_insert  in  DATA_WD  header word; valid bytes are LSB-aligned.
- keep_insert  in  DATA_BYTE_WD  header byte enables, LSB-aligned (e.g. 0111); informational only, not used.
- byte_insert_cnt  in  BYTE_CNT_WD+1  number of header bytes H, 0..DATA_BYTE_WD; this count is authoritative.
- ready_insert  out  1  header accepted when valid_insert & ready_insert.

## Operation
- **States:**
  - IDLE: ready_insert=1 (gated low while rst_n=0), ready_in=0.
  - DATA: ready_in = !valid_out | ready_out.
  - FLUSH: ready_in=0, ready_insert=0.
- **Header capture (IDLE → DATA):** on a header handshake, latch the low H bytes of header_insert into the residual register R (MSB-aligned) and set S=H.
- **DATA beat handling (W=DATA_BYTE_WD):** on each accepted non-last beat:
  - output = R(S bytes) ‖ data_in bytes 0..W-S-1, keep all ones;
  - R ← data_in bytes W-S..W-1.
  - S=0 gives pass-through. S=W emits the pure-header beat first.
- **Last input beat:** let n = popcount(keep_in), with 1≤n≤W; the total remaining byte count is S+n.
  - If S+n ≤ W: emit one beat holding R ‖ first n bytes, keep = top S+n ones, last_out=1; go to IDLE.
  - If S+n > W: emit a full beat with last_out=0, set R ← the remaining S+n-W bytes, and go to FLUSH. In FLUSH, emit R with keep = top S+n-W ones and last_out=1, then go to IDLE.
- **Input preconditions (not checked):** non-last keep_in is all ones, and last-beat keep_in is contiguous and MSB-aligned.
- **Headers across packets:** a new header may be accepted in IDLE while the previous packet's last beat is still held in the output register.
- **keep_insert:** ignored; byte_insert_cnt governs.

## Timing
- **Output register:** the output beat is registered and loads when !valid_out | ready_out. Data, keep and last appear on the edge that accepts the input beat, so latency is 1 cycle.
- **Throughput:** 1 beat/cycle in DATA with ready_out held high. A FLUSH beat costs one extra cycle.
- **Reset:** rst_n low asynchronously clears state to IDLE and drives the outputs as follows:
  - valid_out=0, data_out=0, keep_out=0, last_out=0;
  - ready_in=0, ready_insert=0;
  - R=0, S=0.
- **Backpressure:** while valid_out=1 and ready_out=0, data_out, keep_out and last_out hold stable and ready_in=0.
- **Header during DATA/FLUSH:** not accepted (ready_insert=0); the source holds it.
- **valid_in before a header:** stalls (ready_in=0) until a header is captured.
- **Reset mid-packet:** the packet is discarded and no partial beat is emitted afterwards.

## Test plan
- Spans the 32-bit default; every scenario starts with rst_n low then released.
- **Normal packet, H=3:** header_insert=0x000E0D0C, cnt=3. Payload (last beat keep 1000): 0A0B0C0D, 0E0F0001, 02030405, 06070809, 0A0B0B0B. Required output, all keep 1111: 0E0D0C0A, 0B0C0D0E, 0F000102, 03040506, 0708090A with last_out=1.
- **Flush beat:** same packet but last beat keep 1100. Required: …, 0708090A with last_out=0, then 0B000000 keep 1000 with last_out=1.
- **Pass-through, H=0:** output equals the input beat-for-beat, with keep and last unchanged.
- **Full header, H=4:** header 11223344, then single beat AABBCCDD keep 1111 last. Required: 11223344 keep 1111 not last, then AABBCCDD keep 1111 last.
- **Backpressure:** toggle ready_out randomly. Required: outputs stay stable while stalled, and there is no loss or duplication versus the reference byte stream.
- **Header gating and reset:** valid_in asserted before the header gives ready_in=0. Asserting rst_n mid-packet forces valid_out=0 immediately and returns the block to IDLE.
